// File: rtl/mxv_pkg.sv
// mxv_pkg: shared state encoding, default widths and FP constants for the
// matrix-vector result path.
package mxv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } collector_state_t;

    localparam int DEF_NO_OF_UNITS   = 8;
    localparam int DEF_ELEMENT_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH    = 4;
    localparam int DEF_ADDR_WIDTH    = 10;
    localparam int DEF_COUNT_WIDTH   = 16;

    localparam logic [7:0] FP_EXP_ALL_ONES = 8'hFF;

endpackage

// File: rtl/mxv_result_collector_row_fifo.sv
// row_fifo: synchronous row FIFO; pointers carry an extra wrap bit so full
// and empty are distinguishable. A pop frees a slot for a same-cycle push.
module row_fifo
    import mxv_pkg::*;
#(
    parameter int width = DEF_ELEMENT_WIDTH * DEF_NO_OF_UNITS,
    parameter int depth = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             main_reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [width-1:0] data_i,
    output logic [width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             last_o
);
    localparam int aw = $clog2(depth);

    logic [width-1:0] mem_q [depth];
    logic [aw:0]      wptr_q;
    logic [aw:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = wptr_q == rptr_q;
    assign full_o  = (wptr_q[aw] != rptr_q[aw]) && (wptr_q[aw-1:0] == rptr_q[aw-1:0]);
    assign last_o  = (wptr_q - rptr_q) == (aw+1)'(1);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rptr_q[aw-1:0]];

    always_ff @(posedge clk or negedge main_reset) begin
        if (!main_reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < depth; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q[aw-1:0]] <= data_i;
                wptr_q <= wptr_q + (aw+1)'(1);
            end
            if (do_pop) rptr_q <= rptr_q + (aw+1)'(1);
        end
    end

endmodule

// File: rtl/mxv_result_collector.sv
// mxv_result_collector: packs dot-product results MSB-first into row words,
// buffers rows and drains them to result memory. Optional NaN/Inf flag: MXV_COLLECTOR_FP_CHECK_EN.
module mxv_result_collector
    import mxv_pkg::*;
#(
    parameter int no_of_units   = DEF_NO_OF_UNITS,
    parameter int element_width = DEF_ELEMENT_WIDTH,
    parameter int fifo_depth    = DEF_FIFO_DEPTH,
    parameter int addr_width    = DEF_ADDR_WIDTH,
    parameter int count_width   = DEF_COUNT_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 main_reset,
    input  logic                                 start,
    input  logic [count_width-1:0]               no_of_results,
    input  logic [addr_width-1:0]                base_addr,
    input  logic [element_width-1:0]             dot_product_output,
    input  logic                                 dp_valid,
    input  logic                                 mem_ready,
    output logic                                 wr_en,
    output logic [addr_width-1:0]                wr_addr,
    output logic [element_width*no_of_units-1:0] wr_data,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 overflow,
    output logic                                 fp_exception
);
    localparam int row_width = element_width * no_of_units;
    localparam int kw        = $clog2(no_of_units);

    collector_state_t       state_q, state_d;
    logic [kw-1:0]          k_q, k_d;
    logic [count_width-1:0] cnt_q, cnt_d;
    logic [count_width-1:0] nres_q, nres_d;
    logic [addr_width-1:0]  addr_q, addr_d;
    logic [row_width-1:0]   row_q, row_d;
    logic [row_width-1:0]   lane_row;
    logic                   ovf_q, ovf_d;
    logic                   push;
    logic                   full;
    logic                   empty;
    logic                   last;

    assign wr_en    = !empty && mem_ready;
    assign wr_addr  = addr_q;
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign overflow = ovf_q;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        nres_d   = nres_q;
        addr_d   = addr_q + {{(addr_width-1){1'b0}}, wr_en};
        row_d    = row_q;
        ovf_d    = ovf_q;
        push     = 1'b0;
        lane_row = row_q;
        lane_row[element_width*(no_of_units-int'(k_q))-1 -: element_width] = dot_product_output;
        case (state_q)
            IDLE: if (start) begin
                row_d   = '0;
                k_d     = '0;
                cnt_d   = '0;
                nres_d  = no_of_results;
                addr_d  = base_addr;
                ovf_d   = 1'b0;
                state_d = (no_of_results == '0) ? DONE : COLLECT;
            end
            COLLECT: if (dp_valid) begin
                cnt_d = cnt_q + count_width'(1);
                push  = (k_q == kw'(no_of_units-1)) || (cnt_d == nres_q);
                // Clearing the row after a push zero-pads any partial final row.
                row_d   = push ? '0 : lane_row;
                k_d     = push ? '0 : k_q + kw'(1);
                state_d = (cnt_d == nres_q) ? DRAIN : COLLECT;
            end
            // Leave as the last entry pops so done lands the cycle after that write.
            DRAIN: if (empty || (wr_en && last)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (push && full && !wr_en) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge main_reset) begin
        if (!main_reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            nres_q  <= '0;
            addr_q  <= '0;
            row_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            nres_q  <= nres_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            ovf_q   <= ovf_d;
        end
    end

    row_fifo #(
        .width (row_width),
        .depth (fifo_depth)
    ) u_row_fifo (
        .clk        (clk),
        .main_reset (main_reset),
        .push_i     (push),
        .pop_i      (wr_en),
        .data_i     (lane_row),
        .head_o     (wr_data),
        .full_o     (full),
        .empty_o    (empty),
        .last_o     (last)
    );

`ifdef MXV_COLLECTOR_FP_CHECK_EN
    logic fp_q, fp_d;

    always_comb begin
        fp_d = fp_q;
        if (state_q == IDLE && start) fp_d = 1'b0;
        else if (state_q == COLLECT && dp_valid &&
                 dot_product_output[element_width-2 -: 8] == FP_EXP_ALL_ONES) fp_d = 1'b1;
    end

    always_ff @(posedge clk or negedge main_reset) begin
        if (!main_reset) fp_q <= 1'b0;
        else fp_q <= fp_d;
    end

    assign fp_exception = fp_q;
`else
    assign fp_exception = 1'b0;
`endif

endmodule
